encode_packet_stream: RTL and testbench
=======================================

Name: encode_packet_stream

Overview:
- Parametrised successor of the single-shot DFX packet encoder.
- Takes one wide DFX word (address + data) and slices it into NUM_PKT Aurora-width flits, each carrying a header {TTL, seq number, src router}.
- Adds downstream backpressure (valid/ready), a last-flit marker, run-time TTL/source fields and a derived packet count.
- Sits between the encode controller and the lane input FIFO of the 4-lane router.

Parameters:
- DATA_WIDTH, 1024, DFX data bits
- ADDR_WIDTH, 10, DFX address bits
- DATA_DFX_WIDTH, DATA_WIDTH+ADDR_WIDTH, total bits to packetise
- AURORA_DATA_WIDTH, 256, flit width
- TTL_W, 2, TTL field width
- SEQ_W, 5, sequence-number field width
- SRC_W, 2, source-router field width
- PAYLOAD_W, AURORA_DATA_WIDTH-TTL_W-SEQ_W-SRC_W (247), payload bits per flit
- NUM_PKT, ceil(DATA_DFX_WIDTH/PAYLOAD_W) (5), flits per DFX word

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_encode_pkt  in  1  request to encode data_dfx_send
- data_dfx_send  in  DATA_DFX_WIDTH  word to encode
- cfg_ttl  in  TTL_W  TTL for this word, sampled at accept
- cfg_src_router  in  SRC_W  source router ID, sampled at accept
- ready_encode_pkt  out  1  encoder idle, can accept
- encode_done  out  1  one-cycle pulse after the final flit handshake
- encode_valid  out  1  flit valid toward the FIFO
- fifo_ready  in  1  FIFO can take a flit
- pkt_last  out  1  current flit is the last one (seq = NUM_PKT-1)
- data_send  out  AURORA_DATA_WIDTH  flit

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: all outputs 0, state IDLE, internal registers 0. ready_encode_pkt rises on the first clk edge after reset release.
- Flit format, MSB to LSB: {payload[PAYLOAD_W], ttl[TTL_W], seq[SEQ_W], src[SRC_W]}.
  - Flit k payload = stored_word[k*PAYLOAD_W +: PAYLOAD_W].
  - The last flit carries the remaining DATA_DFX_WIDTH-(NUM_PKT-1)*PAYLOAD_W bits (46 at defaults), right-aligned and zero-padded above.
  - Bits beyond DATA_DFX_WIDTH are never read.
- Elaboration checks: NUM_PKT-1 must fit in SEQ_W and PAYLOAD_W must be >0; otherwise $error.

State machine:
- IDLE: ready_encode_pkt=1.
  - Accept when start_encode_pkt && ready_encode_pkt at an edge.
  - At that edge: latch data_dfx_send, cfg_ttl, cfg_src_router; set ready_encode_pkt<=0, load flit 0 into data_send, encode_valid<=1, pkt_last<=(NUM_PKT==1); go to SEND.
  - First flit is visible the cycle after accept.
- SEND: handshake = encode_valid && fifo_ready.
  - No handshake: data_send, pkt_last and encode_valid hold stable, with no bubble or drop.
  - Handshake on a non-last flit: load flit k+1 at the same edge, so a continuously-ready FIFO takes one flit per cycle with no gaps.
  - Handshake on the last flit: encode_valid<=0, data_send<=0, pkt_last<=0, encode_done<=1; go to DONE.
- DONE: encode_done<=0, ready_encode_pkt<=1; go to IDLE.

Timing and boundary conditions:
- Accept-to-accept minimum is NUM_PKT+2 cycles.
- start_encode_pkt while not ready is ignored and not queued.
- data_dfx_send and cfg_* may change after accept with no effect on the word in flight.
- fifo_ready toggling every cycle: each flit is sent exactly once, in order 0..NUM_PKT-1.
- Reset asserted mid-SEND: immediate return to reset values. The partial flit stream is abandoned and encode_done does not pulse.
- Unreachable state encodings go to IDLE.

Test Plan:
- Defaults, fifo_ready=1, start with data=1034'h3_FFFF...F, cfg_ttl=2, cfg_src=1 -> 5 consecutive valid flits.
  - Flit0 low 9 bits = {2'b10, 5'd0, 2'b01}, payload all ones.
  - Flit4 payload[45:0] all ones with bits 246:46 zero, pkt_last=1 only on flit4.
  - encode_done pulses 1 cycle after flit4; ready returns the next cycle.
- Backpressure: fifo_ready low for 3 cycles during flit2 -> data_send stays constant with valid=1. The seq sequence 0,1,2,3,4 has no duplicates or gaps.
- fifo_ready alternating 1/0 -> exactly 5 handshakes, 10 cycles after the first valid.
- start held high continuously with data changing each cycle -> second word accepted exactly NUM_PKT+2 cycles after the first, with the first word's flits unchanged.
- rst_n pulled low during flit3 -> all outputs 0 asynchronously, no encode_done. A new start after reset yields seq starting at 0.
- Parameter variant AURORA_DATA_WIDTH=128, DATA_WIDTH=256, ADDR_WIDTH=8 -> PAYLOAD_W=119, NUM_PKT=3. Last flit carries 26 bits, and reconstruction of the payloads equals the input word.

Source files
------------

// File: rtl/encode_packet_stream.sv
// encode_packet_stream: slices one wide DFX word (address + data) into NUM_PKT
// Aurora-width flits. Each flit is {payload, ttl, seq, src}. The flits go out
// over a valid/ready handshake, and the last flit is flagged with pkt_last.
module encode_packet_stream #(
  parameter int DATA_WIDTH        = 1024,
  parameter int ADDR_WIDTH        = 10,
  parameter int DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH,
  parameter int AURORA_DATA_WIDTH = 256,
  parameter int TTL_W             = 2,
  parameter int SEQ_W             = 5,
  parameter int SRC_W             = 2,
  parameter int PAYLOAD_W         = AURORA_DATA_WIDTH - TTL_W - SEQ_W - SRC_W,
  parameter int NUM_PKT           = (PAYLOAD_W > 0) ?
                                    (DATA_DFX_WIDTH + PAYLOAD_W - 1) / PAYLOAD_W : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_encode_pkt,
  input  logic [DATA_DFX_WIDTH-1:0]    data_dfx_send,
  input  logic [TTL_W-1:0]             cfg_ttl,
  input  logic [SRC_W-1:0]             cfg_src_router,
  output logic                         ready_encode_pkt,
  output logic                         encode_done,
  output logic                         encode_valid,
  input  logic                         fifo_ready,
  output logic                         pkt_last,
  output logic [AURORA_DATA_WIDTH-1:0] data_send
);

  // The word is zero-extended to a whole number of payload slices, so the
  // last flit is automatically right-aligned and zero-padded above.
  localparam int PAD_W = NUM_PKT * PAYLOAD_W;
  localparam logic [SEQ_W-1:0] SEQ_LAST = SEQ_W'(NUM_PKT - 1);

  generate
    if (PAYLOAD_W <= 0 || (NUM_PKT - 1) >= (1 << SEQ_W)) begin : g_param_check
      $error("encode_packet_stream: PAYLOAD_W must be >0 and NUM_PKT-1 must fit in SEQ_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [DATA_DFX_WIDTH-1:0] word_q;
  logic [TTL_W-1:0]          ttl_q;
  logic [SRC_W-1:0]          src_q;
  logic [SEQ_W-1:0]          seq_q;

  logic                         handshake;
  logic                         accept;
  logic [PAD_W-1:0]             word_pad;
  logic [SEQ_W-1:0]             flit_idx;
  logic [TTL_W-1:0]             flit_ttl;
  logic [SRC_W-1:0]             flit_src;
  logic [AURORA_DATA_WIDTH-1:0] next_flit;
  logic                         next_last;

  assign handshake = encode_valid && fifo_ready;
  assign accept    = (state_q == IDLE) && start_encode_pkt && ready_encode_pkt;

  // Build the next flit. In IDLE this is flit 0 taken straight from the inputs.
  // In SEND it is flit seq+1 taken from the latched word.
  always_comb begin
    word_pad = '0;
    flit_idx = '0;
    flit_ttl = cfg_ttl;
    flit_src = cfg_src_router;
    if (state_q == IDLE) begin
      word_pad[DATA_DFX_WIDTH-1:0] = data_dfx_send;
    end else begin
      word_pad[DATA_DFX_WIDTH-1:0] = word_q;
      flit_ttl = ttl_q;
      flit_src = src_q;
      flit_idx = pkt_last ? seq_q : seq_q + 1'b1;
    end
    next_flit = {word_pad[int'(flit_idx) * PAYLOAD_W +: PAYLOAD_W], flit_ttl, flit_idx, flit_src};
    next_last = (flit_idx == SEQ_LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. Unused encodings fall back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SEND;
      SEND:    if (handshake && pkt_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs: latch on accept, advance on each handshake,
  // and pulse done after the final flit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q           <= '0;
      ttl_q            <= '0;
      src_q            <= '0;
      seq_q            <= '0;
      ready_encode_pkt <= 1'b0;
      encode_done      <= 1'b0;
      encode_valid     <= 1'b0;
      pkt_last         <= 1'b0;
      data_send        <= '0;
    end else begin
      encode_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            word_q           <= data_dfx_send;
            ttl_q            <= cfg_ttl;
            src_q            <= cfg_src_router;
            seq_q            <= '0;
            ready_encode_pkt <= 1'b0;
            encode_valid     <= 1'b1;
            data_send        <= next_flit;
            pkt_last         <= next_last;
          end else begin
            ready_encode_pkt <= 1'b1;
          end
        end
        SEND: begin
          if (handshake) begin
            if (pkt_last) begin
              encode_valid <= 1'b0;
              data_send    <= '0;
              pkt_last     <= 1'b0;
              encode_done  <= 1'b1;
            end else begin
              seq_q     <= flit_idx;
              data_send <= next_flit;
              pkt_last  <= next_last;
            end
          end
        end
        DONE: begin
          ready_encode_pkt <= 1'b1;
        end
        default: begin
          ready_encode_pkt <= 1'b0;
          encode_valid     <= 1'b0;
          pkt_last         <= 1'b0;
          data_send        <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encode_packet_stream.sv
// Self-checking bench for encode_packet_stream. It covers the default
// configuration (1034-bit word, 5 flits) and a small variant (264-bit word,
// 3 flits). Expected flits come from a shift-and-slice model of the flit format.
module tb_encode_packet_stream;

  localparam int DW  = 1034;
  localparam int AW  = 256;
  localparam int PW  = 247;
  localparam int NP  = 5;
  localparam int VDW = 264;
  localparam int VAW = 128;
  localparam int VPW = 119;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] data;
  logic [1:0]    ttl, src;
  logic          fifo_ready;
  logic          ready, done, valid, last;
  logic [AW-1:0] dsend;

  logic           v_start;
  logic [VDW-1:0] v_data;
  logic [1:0]     v_ttl, v_src;
  logic           v_fifo_ready;
  logic           v_ready, v_done, v_valid, v_last;
  logic [VAW-1:0] v_dsend;

  int checks = 0;
  int errors = 0;

  // Results filled in by collect().
  logic [AW-1:0] got_flit[8];
  logic          got_last[8];
  int            got_c[8];
  int            got_n, done_c, ready_c, hold_err, extra_done;
  bit            timed_out;

  always #5 clk = ~clk;

  encode_packet_stream dut (
    .clk(clk), .rst_n(rst_n), .start_encode_pkt(start), .data_dfx_send(data),
    .cfg_ttl(ttl), .cfg_src_router(src), .ready_encode_pkt(ready),
    .encode_done(done), .encode_valid(valid), .fifo_ready(fifo_ready),
    .pkt_last(last), .data_send(dsend)
  );

  encode_packet_stream #(.DATA_WIDTH(256), .ADDR_WIDTH(8), .AURORA_DATA_WIDTH(128)) vdut (
    .clk(clk), .rst_n(rst_n), .start_encode_pkt(v_start), .data_dfx_send(v_data),
    .cfg_ttl(v_ttl), .cfg_src_router(v_src), .ready_encode_pkt(v_ready),
    .encode_done(v_done), .encode_valid(v_valid), .fifo_ready(v_fifo_ready),
    .pkt_last(v_last), .data_send(v_dsend)
  );

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < 33; i++) w = {w[DW-33:0], 32'($urandom)};
    return w;
  endfunction

  function automatic logic [VDW-1:0] rand_vword();
    logic [VDW-1:0] w;
    w = '0;
    for (int i = 0; i < 9; i++) w = {w[VDW-33:0], 32'($urandom)};
    return w;
  endfunction

  // Reference flit k: shift the word down by k payloads and keep the low PW bits.
  function automatic logic [AW-1:0] model_flit(input logic [DW-1:0] w, input int k,
                                               input logic [1:0] t, input logic [1:0] s);
    logic [DW-1:0] sh;
    sh = w >> (k * PW);
    return {sh[PW-1:0], t, 5'(k), s};
  endfunction

  // Wait for ready (bounded), present one word for one cycle, then scramble inputs.
  task automatic start_word(input logic [DW-1:0] w, input logic [1:0] t, input logic [1:0] s);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ready) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL start_wait: ready got 0 required 1 within 30 cycles");
    end
    data  = w;
    ttl   = t;
    src   = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    data  = rand_word();
    ttl   = 2'($urandom);
    src   = 2'($urandom);
  endtask

  // Drive fifo_ready with a pattern and record every handshaken flit.
  // Modes: 0 always ready, 1 random, 2 alternating starting low, 3 stall flit 2 for 3 cycles.
  task automatic collect(input int mode);
    logic [AW-1:0] prev_d;
    bit            prev_stall;
    int            stall;
    logic          fr;
    prev_stall = 1'b0;
    prev_d     = '0;
    stall      = 0;
    got_n = 0; done_c = -1; ready_c = -1; hold_err = 0; extra_done = 0; timed_out = 1'b1;
    for (int c = 0; c < 80; c++) begin
      if (prev_stall && (!valid || dsend !== prev_d)) hold_err++;
      if (done) begin
        if (done_c < 0) done_c = c;
        else extra_done++;
      end
      if (ready) begin ready_c = c; timed_out = 1'b0; break; end
      case (mode)
        0:       fr = 1'b1;
        1:       fr = 1'($urandom_range(0, 1));
        2:       fr = (c % 2 == 1);
        3: begin
          fr = !(got_n == 2 && stall < 3);
          if (!fr) stall++;
        end
        default: fr = 1'b1;
      endcase
      fifo_ready = fr;
      prev_stall = valid && !fr;
      prev_d     = dsend;
      if (valid && fr) begin
        if (got_n < 8) begin
          got_flit[got_n] = dsend;
          got_last[got_n] = last;
          got_c[got_n]    = c;
        end
        got_n++;
      end
      @(negedge clk);
    end
    fifo_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b required 0", valid); end
    checks++; if (last !== 1'b0) begin errors++; $display("[TB] FAIL reset_last: got %b required 0", last); end
    checks++; if (dsend !== '0) begin errors++; $display("[TB] FAIL reset_data: got %h required 0", dsend); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b required 0", done); end
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b required 0", ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL ready_before_edge: got %b required 0", ready); end
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_edge: got %b required 1", ready); end
    checks++; if (v_ready !== 1'b1) begin errors++; $display("[TB] FAIL v_ready_after_edge: got %b required 1", v_ready); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] w;
    logic [AW-1:0] exp4;
    w    = '1;
    exp4 = {201'd0, {46{1'b1}}, 2'b10, 5'd4, 2'b01};
    start_word(w, 2'd2, 2'd1);
    collect(0);
    checks++; if (got_n !== NP) begin errors++; $display("[TB] FAIL basic_count: got %0d required %0d", got_n, NP); end
    checks++; if (got_flit[0][8:0] !== 9'b10_00000_01) begin errors++; $display("[TB] FAIL basic_hdr0: got %b required 100000001", got_flit[0][8:0]); end
    checks++; if (got_flit[0][AW-1:9] !== {PW{1'b1}}) begin errors++; $display("[TB] FAIL basic_payload0: got %h required all ones", got_flit[0][AW-1:9]); end
    checks++; if (got_flit[4] !== exp4) begin errors++; $display("[TB] FAIL basic_flit4: got %h required %h", got_flit[4], exp4); end
    for (int k = 0; k < NP; k++) begin
      checks++;
      if (got_last[k] !== (k == NP - 1) || got_c[k] !== k) begin
        errors++;
        $display("[TB] FAIL basic_timing%0d: last %b cycle %0d required last %b cycle %0d", k, got_last[k], got_c[k], (k == NP - 1), k);
      end
    end
    checks++; if (done_c !== 5 || extra_done !== 0) begin errors++; $display("[TB] FAIL basic_done: cycle %0d extra %0d required cycle 5 extra 0", done_c, extra_done); end
    checks++; if (ready_c !== 6) begin errors++; $display("[TB] FAIL basic_ready: cycle %0d required 6", ready_c); end
  endtask

  task automatic test_random();
    logic [DW-1:0] w;
    logic [1:0]    t, s;
    logic [AW-1:0] e;
    for (int it = 0; it < 6; it++) begin
      w = rand_word(); t = 2'($urandom); s = 2'($urandom);
      start_word(w, t, s);
      collect(1);
      checks++; if (got_n !== NP || timed_out) begin errors++; $display("[TB] FAIL rand%0d_count: got %0d timeout %b required %0d", it, got_n, timed_out, NP); end
      for (int k = 0; k < NP && k < got_n; k++) begin
        e = model_flit(w, k, t, s);
        checks++;
        if (got_flit[k] !== e || got_last[k] !== (k == NP - 1)) begin
          errors++;
          $display("[TB] FAIL rand%0d_flit%0d: got %h/%b required %h/%b", it, k, got_flit[k], got_last[k], e, (k == NP - 1));
        end
      end
      checks++; if (hold_err !== 0) begin errors++; $display("[TB] FAIL rand%0d_hold: got %0d unstable stalls required 0", it, hold_err); end
      checks++; if (done_c < 0 || ready_c !== done_c + 1 || extra_done !== 0) begin errors++; $display("[TB] FAIL rand%0d_done: done %0d ready %0d required ready one after done", it, done_c, ready_c); end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w;
    logic [AW-1:0] e;
    w = rand_word();
    start_word(w, 2'd1, 2'd3);
    collect(3);
    checks++; if (got_n !== NP) begin errors++; $display("[TB] FAIL bp_count: got %0d required %0d", got_n, NP); end
    for (int k = 0; k < NP && k < got_n; k++) begin
      e = model_flit(w, k, 2'd1, 2'd3);
      checks++; if (got_flit[k] !== e) begin errors++; $display("[TB] FAIL bp_flit%0d: got %h required %h", k, got_flit[k], e); end
    end
    checks++; if (hold_err !== 0) begin errors++; $display("[TB] FAIL bp_hold: got %0d required 0", hold_err); end
    checks++; if (got_c[2] !== 5 || done_c !== 8) begin errors++; $display("[TB] FAIL bp_timing: flit2 at %0d done at %0d required 5 and 8", got_c[2], done_c); end
  endtask

  task automatic test_alternating();
    logic [DW-1:0] w;
    logic [AW-1:0] e;
    w = rand_word();
    start_word(w, 2'd3, 2'd2);
    collect(2);
    checks++; if (got_n !== NP) begin errors++; $display("[TB] FAIL alt_count: got %0d required %0d", got_n, NP); end
    for (int k = 0; k < NP && k < got_n; k++) begin
      e = model_flit(w, k, 2'd3, 2'd2);
      checks++; if (got_flit[k] !== e) begin errors++; $display("[TB] FAIL alt_flit%0d: got %h required %h", k, got_flit[k], e); end
    end
    checks++; if (got_c[4] !== 9 || done_c !== 10) begin errors++; $display("[TB] FAIL alt_timing: last handshake %0d done %0d required 9 and 10", got_c[4], done_c); end
    checks++; if (hold_err !== 0) begin errors++; $display("[TB] FAIL alt_hold: got %0d required 0", hold_err); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] hist[24];
    logic [AW-1:0] obs[24];
    logic          obs_v[24];
    int            firsts[4];
    int            nf;
    logic [AW-1:0] e;
    logic [1:0]    t, s;
    t = 2'($urandom); s = 2'($urandom);
    nf = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ready) break;
    end
    ttl = t; src = s; fifo_ready = 1'b1; start = 1'b1;
    for (int c = 0; c < 24; c++) begin
      obs[c]   = dsend;
      obs_v[c] = valid;
      if (valid && dsend[6:2] == 5'd0 && c >= 1 && nf < 4) begin
        firsts[nf] = c;
        nf++;
      end
      data    = rand_word();
      hist[c] = data;
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (nf < 2) begin errors++; $display("[TB] FAIL b2b_words: got %0d first flits required at least 2", nf); end
    if (nf >= 2) begin
      checks++; if (firsts[1] - firsts[0] !== NP + 2) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d cycles required %0d", firsts[1] - firsts[0], NP + 2); end
      for (int k = 0; k < NP; k++) begin
        e = model_flit(hist[firsts[0] - 1], k, t, s);
        checks++;
        if (obs[firsts[0] + k] !== e || obs_v[firsts[0] + k] !== 1'b1) begin
          errors++;
          $display("[TB] FAIL b2b_w0_flit%0d: got %h required %h", k, obs[firsts[0] + k], e);
        end
      end
      e = model_flit(hist[firsts[1] - 1], 0, t, s);
      checks++; if (obs[firsts[1]] !== e) begin errors++; $display("[TB] FAIL b2b_w1_flit0: got %h required %h", obs[firsts[1]], e); end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_mid_send();
    logic [DW-1:0] w;
    logic [AW-1:0] e;
    w = rand_word();
    start_word(w, 2'd2, 2'd2);
    fifo_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (dsend[6:2] !== 5'd3 || valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_seq: got seq %0d valid %b required 3 and 1", dsend[6:2], valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || last !== 1'b0 || dsend !== '0 || done !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_async: valid %b last %b done %b ready %b data %h required all zero", valid, last, done, ready, dsend);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (done !== 1'b0 || ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_recover: done %b ready %b required 0 and 1", done, ready); end
    w = rand_word();
    start_word(w, 2'd1, 2'd0);
    collect(0);
    e = model_flit(w, 0, 2'd1, 2'd0);
    checks++; if (got_flit[0] !== e) begin errors++; $display("[TB] FAIL rst_new_flit0: got %h required %h", got_flit[0], e); end
    checks++; if (got_n !== NP || done_c !== 5) begin errors++; $display("[TB] FAIL rst_new_word: count %0d done %0d required %0d and 5", got_n, done_c, NP); end
  endtask

  task automatic test_variant();
    logic [VDW-1:0] w, rec, tmp;
    logic [VAW-1:0] vf[4];
    logic           vl[4];
    logic [1:0]     t, s;
    int             n, vdone;
    logic           fr;
    for (int it = 0; it < 4; it++) begin
      w = rand_vword(); t = 2'($urandom); s = 2'($urandom);
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (v_ready) break;
      end
      v_data = w; v_ttl = t; v_src = s; v_start = 1'b1;
      @(negedge clk);
      v_start = 1'b0; v_data = rand_vword(); v_ttl = 2'($urandom); v_src = 2'($urandom);
      n = 0; vdone = -1;
      for (int c = 0; c < 60; c++) begin
        if (v_done) begin vdone = c; break; end
        fr = 1'($urandom_range(0, 1));
        v_fifo_ready = fr;
        if (v_valid && fr) begin
          if (n < 4) begin vf[n] = v_dsend; vl[n] = v_last; end
          n++;
        end
        @(negedge clk);
      end
      v_fifo_ready = 1'b0;
      checks++; if (n !== 3 || vdone < 0) begin errors++; $display("[TB] FAIL var%0d_count: got %0d flits done %0d required 3 and a pulse", it, n, vdone); end
      rec = '0;
      for (int k = 0; k < 3 && k < n; k++) begin
        tmp = '0;
        tmp[VPW-1:0] = vf[k][VAW-1:9];
        rec = rec | (tmp << (k * VPW));
        checks++;
        if (vf[k][8:7] !== t || vf[k][6:2] !== 5'(k) || vf[k][1:0] !== s || vl[k] !== (k == 2)) begin
          errors++;
          $display("[TB] FAIL var%0d_hdr%0d: got ttl %0d seq %0d src %0d last %b required %0d %0d %0d %b", it, k, vf[k][8:7], vf[k][6:2], vf[k][1:0], vl[k], t, k, s, (k == 2));
        end
      end
      checks++; if (rec !== w) begin errors++; $display("[TB] FAIL var%0d_rebuild: got %h required %h", it, rec, w); end
      if (n >= 3) begin
        checks++; if (vf[2][VAW-1:35] !== '0) begin errors++; $display("[TB] FAIL var%0d_pad: got %h required 0", it, vf[2][VAW-1:35]); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; data = '0; ttl = '0; src = '0; fifo_ready = 1'b1;
    v_start = 1'b0; v_data = '0; v_ttl = '0; v_src = '0; v_fifo_ready = 1'b0;
    test_reset();
    test_basic();
    test_random();
    test_backpressure();
    test_alternating();
    test_back_to_back();
    test_reset_mid_send();
    test_variant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
